// File: rtl/write_ctrl_pkg.sv
// Shared types and sizes for the write-channel controller.
//   wr_state_e  : controller FSM states
//   SLV_IDX_W   : width of a slave index
//   NUM_SLAVES  : number of address-mapped slaves
package write_ctrl_pkg;

    localparam int SLV_IDX_W  = 2;
    localparam int NUM_SLAVES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/write_addr_decoder.sv
// Address range decoder for the write-address path.
// Ports:
//   addr         : address to decode
//   lo0..lo3     : inclusive lower bound of each slave range
//   hi0..hi3     : inclusive upper bound of each slave range
//   idx          : index of the matching slave (0 when nothing matches)
//   hit          : 1 when at least one range contains addr
module write_addr_decoder
    import write_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] lo0,
    input  logic [ADDR_WIDTH-1:0] lo1,
    input  logic [ADDR_WIDTH-1:0] lo2,
    input  logic [ADDR_WIDTH-1:0] lo3,
    input  logic [ADDR_WIDTH-1:0] hi0,
    input  logic [ADDR_WIDTH-1:0] hi1,
    input  logic [ADDR_WIDTH-1:0] hi2,
    input  logic [ADDR_WIDTH-1:0] hi3,
    output logic [SLV_IDX_W-1:0]  idx,
    output logic                  hit
);

    logic [NUM_SLAVES-1:0] in_range;

    assign in_range[0] = (addr >= lo0) && (addr <= hi0);
    assign in_range[1] = (addr >= lo1) && (addr <= hi1);
    assign in_range[2] = (addr >= lo2) && (addr <= hi2);
    assign in_range[3] = (addr >= lo3) && (addr <= hi3);

    // Scan from the highest index down so the lowest matching index is the
    // last one written; overlapping ranges therefore resolve to the lowest.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (in_range[k]) begin
                idx = SLV_IDX_W'(k);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_controller.sv
// Write-channel controller for a 2-master / 4-slave interconnect.
// Arbitrates AW requests round-robin, decodes the address to a slave,
// steers AW/W/B handshakes and keeps one write outstanding at a time.
// Ports:
//   clkk, resett                  : clock, async active-low reset
//   slaveN_addr1 / slaveN_addr2   : inclusive range bounds of slave N
//   M_ADDR                        : AWADDR of the granted master
//   M0/M1_AWVALID                 : master write-address requests
//   S0..S3_AWREADY/WREADY/BVALID  : slave handshakes
//   M_WVALID, M_WLAST             : muxed write-data valid / last
//   M0/M1_BREADY                  : master response ready
//   select_master_address         : granted master (AW/W mux select)
//   select_slave_address          : decoded slave for the AW path
//   select_write_slave            : latched slave for the W/B paths
//   en_S0..en_S3                  : per-slave valid gates
//   resp_valid_M0/M1              : routed BVALID per master
//   addr_error                    : one-cycle pulse on unmapped address
//   busy                          : FSM not idle
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | no transaction; arbitrate pending AW requests
// ADDR    | granted master's address decoded, waiting for AWREADY
// DATA    | data beats flowing to the latched slave until WLAST
// RESP    | routing the slave's BVALID back to the granted master
module write_controller
    import write_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clkk,
    input  logic                  resett,
    input  logic [ADDR_WIDTH-1:0] slave0_addr1,
    input  logic [ADDR_WIDTH-1:0] slave1_addr1,
    input  logic [ADDR_WIDTH-1:0] slave2_addr1,
    input  logic [ADDR_WIDTH-1:0] slave3_addr1,
    input  logic [ADDR_WIDTH-1:0] slave0_addr2,
    input  logic [ADDR_WIDTH-1:0] slave1_addr2,
    input  logic [ADDR_WIDTH-1:0] slave2_addr2,
    input  logic [ADDR_WIDTH-1:0] slave3_addr2,
    input  logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic                  M0_AWVALID,
    input  logic                  M1_AWVALID,
    input  logic                  S0_AWREADY,
    input  logic                  S1_AWREADY,
    input  logic                  S2_AWREADY,
    input  logic                  S3_AWREADY,
    input  logic                  M_WVALID,
    input  logic                  M_WLAST,
    input  logic                  S0_WREADY,
    input  logic                  S1_WREADY,
    input  logic                  S2_WREADY,
    input  logic                  S3_WREADY,
    input  logic                  S0_BVALID,
    input  logic                  S1_BVALID,
    input  logic                  S2_BVALID,
    input  logic                  S3_BVALID,
    input  logic                  M0_BREADY,
    input  logic                  M1_BREADY,
    output logic                  select_master_address,
    output logic [1:0]            select_slave_address,
    output logic [1:0]            select_write_slave,
    output logic                  en_S0,
    output logic                  en_S1,
    output logic                  en_S2,
    output logic                  en_S3,
    output logic                  resp_valid_M0,
    output logic                  resp_valid_M1,
    output logic                  addr_error,
    output logic                  busy
);

    wr_state_e             state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [SLV_IDX_W-1:0]  wsel_q, wsel_d;

    logic [SLV_IDX_W-1:0]  dec_idx;
    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] awready, wready, bvalid, en;
    logic                  bready_g;

    assign awready  = {S3_AWREADY, S2_AWREADY, S1_AWREADY, S0_AWREADY};
    assign wready   = {S3_WREADY, S2_WREADY, S1_WREADY, S0_WREADY};
    assign bvalid   = {S3_BVALID, S2_BVALID, S1_BVALID, S0_BVALID};
    assign bready_g = grant_q ? M1_BREADY : M0_BREADY;

    write_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dec (
        .addr (M_ADDR),
        .lo0  (slave0_addr1),
        .lo1  (slave1_addr1),
        .lo2  (slave2_addr1),
        .lo3  (slave3_addr1),
        .hi0  (slave0_addr2),
        .hi1  (slave1_addr2),
        .hi2  (slave2_addr2),
        .hi3  (slave3_addr2),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wsel_d  = wsel_q;
        case (state_q)
            ST_IDLE: begin
                if (M0_AWVALID | M1_AWVALID) begin
                    // Contest goes to the master that did not win last time.
                    if (M0_AWVALID & M1_AWVALID) grant_d = ~last_q;
                    else                         grant_d = M1_AWVALID;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // AWVALID is deliberately ignored here: a master withdrawing
                // its request mid-address does not unwind the grant.
                if (!dec_hit) begin
                    state_d = ST_IDLE;
                end else if (awready[dec_idx]) begin
                    wsel_d  = dec_idx;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (M_WVALID & wready[wsel_q] & M_WLAST) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bvalid[wsel_q] & bready_g) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkk or negedge resett) begin
        if (!resett) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wsel_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wsel_q  <= wsel_d;
        end
    end

    always_comb begin
        en                   = '0;
        select_slave_address = '0;
        addr_error           = 1'b0;
        resp_valid_M0        = 1'b0;
        resp_valid_M1        = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (dec_hit) begin
                    en[dec_idx]          = 1'b1;
                    select_slave_address = dec_idx;
                end else begin
                    addr_error = 1'b1;
                end
            end
            ST_DATA: en[wsel_q] = 1'b1;
            ST_RESP: begin
                resp_valid_M0 = ~grant_q & bvalid[wsel_q];
                resp_valid_M1 =  grant_q & bvalid[wsel_q];
            end
            default: ;
        endcase
    end

    assign en_S0                 = en[0];
    assign en_S1                 = en[1];
    assign en_S2                 = en[2];
    assign en_S3                 = en[3];
    assign select_master_address = grant_q;
    assign select_write_slave    = wsel_q;
    assign busy                  = (state_q != ST_IDLE);

endmodule
